// File: rtl/gpio_control_ip_if.sv
// Register-bus interface for gpio_control_ip.
// Single-cycle we/re strobes with registered read data.
interface gpio_control_ip_if #(
   parameter int WIDTH = 32
);
   logic             we;
   logic             re;
   logic [3:0]       addr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;

   modport master (
      output we, re, addr, wdata,
      input  rdata
   );

   modport slave (
      input  we, re, addr, wdata,
      output rdata
   );
endinterface

// File: rtl/gpio_control_ip.sv
// GPIO controller: OUT/DIR registers, PINS readback, TOGGLE write port.
// Define GPIO_SYNC_EN to pass gpio_in through a 2-flop synchronizer.
module gpio_control_ip #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   gpio_control_ip_if.slave bus,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_dir
);

   typedef enum logic [1:0] {
      A_OUT  = 2'd0,
      A_DIR  = 2'd1,
      A_PINS = 2'd2,
      A_TGL  = 2'd3
   } addr_e;

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] dir_q;
   logic [WIDTH-1:0] rdata_q;
   logic [WIDTH-1:0] in_s;
   logic [WIDTH-1:0] pins;
   logic [WIDTH-1:0] rd_mux;
   addr_e            sel;
   logic             unused_addr;

   assign sel         = addr_e'(bus.addr[3:2]);
   assign unused_addr = &{1'b0, bus.addr[1:0]};

`ifdef GPIO_SYNC_EN
   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= gpio_in;
         sync2_q <= sync1_q;
      end
   end

   assign in_s = sync2_q;
`else
   assign in_s = gpio_in;
`endif

   // Output-mode pins read back their own OUT bit, not the pad.
   assign pins = (dir_q & out_q) | (~dir_q & in_s);

   always_comb begin
      rd_mux = '0;
      unique case (sel)
         A_OUT:  rd_mux = out_q;
         A_DIR:  rd_mux = dir_q;
         A_PINS: rd_mux = pins;
         A_TGL:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q   <= '0;
         dir_q   <= '0;
         rdata_q <= '0;
      end else begin
         if (bus.re) begin
            rdata_q <= rd_mux;
         end
         if (bus.we) begin
            unique case (sel)
               A_OUT:  out_q <= bus.wdata;
               A_DIR:  dir_q <= bus.wdata;
               A_PINS: ;
               A_TGL:  out_q <= out_q ^ bus.wdata;
            endcase
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign gpio_out  = out_q;
   assign gpio_dir  = dir_q;

endmodule

// File: tb/tb_gpio_control_ip.sv
// Testbench for gpio_control_ip: directed register-map checks plus
// randomized bus traffic compared each cycle against a behavioural model.
module tb_gpio_control_ip;
   localparam int W = 32;
`ifdef GPIO_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] gpio_in = '0;
   logic [W-1:0] gpio_out;
   logic [W-1:0] gpio_dir;
   int           checks = 0;
   int           errors = 0;
   bit           cmp_en = 1'b0;

   gpio_control_ip_if #(.WIDTH(W)) bus ();

   gpio_control_ip #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_dir (gpio_dir)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference model: register file plus a delay line for the input path.
   logic [W-1:0] m_out, m_dir, m_rdata, m_h0, m_h1;

   always @(posedge clk or negedge reset) begin : model
      logic [W-1:0] in_v;
      logic [W-1:0] pins_v;
      if (!reset) begin
         m_out   <= '0;
         m_dir   <= '0;
         m_rdata <= '0;
         m_h0    <= '0;
         m_h1    <= '0;
      end else begin
`ifdef GPIO_SYNC_EN
         in_v = m_h1;
`else
         in_v = gpio_in;
`endif
         for (int i = 0; i < W; i++)
            pins_v[i] = m_dir[i] ? m_out[i] : in_v[i];
         if (bus.re) begin
            case (bus.addr[3:2])
               2'd0:    m_rdata <= m_out;
               2'd1:    m_rdata <= m_dir;
               2'd2:    m_rdata <= pins_v;
               default: m_rdata <= '0;
            endcase
         end
         if (bus.we) begin
            case (bus.addr[3:2])
               2'd0:    m_out <= bus.wdata;
               2'd1:    m_dir <= bus.wdata;
               2'd3:    m_out <= m_out ^ bus.wdata;
               default: ;
            endcase
         end
         m_h1 <= m_h0;
         m_h0 <= gpio_in;
      end
   end

   always @(negedge clk) begin
      if (reset && cmp_en) begin
         chk("cyc_gpio_out", gpio_out, m_out);
         chk("cyc_gpio_dir", gpio_dir, m_dir);
         chk("cyc_rdata", bus.rdata, m_rdata);
      end
   end

   task automatic bus_op(input logic w, input logic r, input logic [3:0] a,
                         input logic [W-1:0] d);
      @(negedge clk);
      bus.we = w;
      bus.re = r;
      bus.addr = a;
      bus.wdata = d;
      @(posedge clk);
      #1;
      bus.we = 1'b0;
      bus.re = 1'b0;
   endtask

   task automatic rand_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         bus.we = 1'($urandom_range(0, 1));
         bus.re = 1'($urandom_range(0, 1));
         bus.addr = 4'($urandom);
         bus.wdata = $urandom;
         if ($urandom_range(0, 3) == 0) gpio_in = $urandom;
      end
      @(negedge clk);
      bus.we = 1'b0;
      bus.re = 1'b0;
   endtask

   initial begin
      bus.we = 1'b0;
      bus.re = 1'b0;
      bus.addr = '0;
      bus.wdata = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_gpio_out", gpio_out, 32'h0);
      chk("rst_gpio_dir", gpio_dir, 32'h0);
      chk("rst_rdata", bus.rdata, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      cmp_en = 1'b1;

      bus_op(1, 0, 4'h4, 32'h0000_000F);
      bus_op(1, 0, 4'h0, 32'h0000_0005);
      chk("wr_dir", gpio_dir, 32'h0000_000F);
      chk("wr_out", gpio_out, 32'h0000_0005);
      bus_op(0, 1, 4'h8, 32'h0);
      chk("rd_pins_a", bus.rdata, 32'h0000_0005);

      @(negedge clk);
      gpio_in = 32'h0000_00A0;
      repeat (3) @(posedge clk);
      bus_op(0, 1, 4'h8, 32'h0);
      chk("rd_pins_b", bus.rdata, 32'h0000_00A5);
      @(negedge clk);
      gpio_in = 32'h0000_000A;
      repeat (3) @(posedge clk);
      bus_op(0, 1, 4'hA, 32'h0);
      chk("rd_pins_mask", bus.rdata, 32'h0000_0005);

      bus_op(1, 0, 4'hC, 32'h0000_000F);
      chk("toggle_out", gpio_out, 32'h0000_000A);
      chk("model_toggle", m_out, 32'h0000_000A);
      bus_op(0, 1, 4'hC, 32'h0);
      chk("rd_toggle", bus.rdata, 32'h0);
      bus_op(0, 1, 4'h1, 32'h0);
      chk("rd_out", bus.rdata, 32'h0000_000A);

      bus_op(1, 1, 4'h0, 32'h1234_5678);
      chk("rw_rdata", bus.rdata, 32'h0000_000A);
      chk("rw_out", gpio_out, 32'h1234_5678);
      @(posedge clk);
      #1;
      chk("rd_hold", bus.rdata, 32'h0000_000A);

      // Input latency: bit 8 is an input pin, low nibble comes from OUT.
      @(negedge clk);
      gpio_in = 32'h0000_010A;
      bus.re = 1'b1;
      bus.addr = 4'h8;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("lat_read%0d", k), bus.rdata,
             (k >= LAT) ? 32'h0000_0108 : 32'h0000_0008);
      end
      @(negedge clk);
      bus.re = 1'b0;
      chk("model_pins", m_rdata, 32'h0000_0108);

      rand_cycles(400);
      bus_op(1, 0, 4'h4, $urandom);
      rand_cycles(300);

      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("mid_rst_out", gpio_out, 32'h0);
      chk("mid_rst_dir", gpio_dir, 32'h0);
      chk("mid_rst_rdata", bus.rdata, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      rand_cycles(200);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpio_control_ip.md
Name: gpio_control_ip

Overview:
- Memory-mapped 32-bit general-purpose I/O controller on a simple single-cycle register bus (we/re/addr/wdata/rdata).
- Holds an output-data register and a per-pin direction register, and reports the composite pin state on readback.
- Sits between the CPU bus fabric and the chip pad ring; pad buffers use gpio_dir as output enable (1 = output).

Parameters:
- WIDTH, 32, number of GPIO pins; bus data width equals WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- we  input  1  write strobe, sampled on rising clk.
- re  input  1  read strobe, sampled on rising clk.
- addr  input  4  byte address; only addr[3:2] decoded, addr[1:0] ignored.
- wdata  input  WIDTH  write data.
- rdata  output  WIDTH  registered read data.
- gpio_in  input  WIDTH  pad input values.
- gpio_out  output  WIDTH  pad output values (equals OUT register).
- gpio_dir  output  WIDTH  pad direction, 1 = drive output, 0 = input (equals DIR register).

Behaviour:
- Register map (addr[3:2]): 0x0 OUT (RW); 0x4 DIR (RW); 0x8 PINS (RO); 0xC TOGGLE (WO, reads 0).
- Reset (reset=0, asynchronous): OUT=0, DIR=0, rdata=0, synchronizer flops=0. Release is sampled on the next clk edge.
- Write: on a rising clk with we=1:
  - OUT/DIR are loaded with wdata, full word.
  - TOGGLE: OUT <= OUT ^ wdata.
  - Writes to PINS are ignored.
  - New value is visible on gpio_out/gpio_dir immediately after that edge.
- PINS value, per bit i: DIR[i] ? OUT[i] : in_s[i]. in_s is gpio_in, or its synchronized copy when GPIO_SYNC_EN is defined.
- Read: on a rising clk with re=1, rdata <= selected register. The value is valid after that edge, i.e. one-cycle latency.
  - When re=0, rdata holds its last value.
  - Reading TOGGLE returns 0.
- Simultaneous we=1 and re=1:
  - Both occur at the same edge.
  - rdata returns the pre-write register contents.
  - For PINS, rdata is computed from the pre-write OUT/DIR.
- No bus errors or wait states; any addr is accepted.
- gpio_out is not masked by DIR: pins in input mode still present OUT on gpio_out, and the pad ignores it.
- Reset asserted mid-operation clears all state immediately; an in-flight access is lost.

Optional Feature:
- Macro GPIO_SYNC_EN.
- Defined:
  - gpio_in passes through a 2-flop synchronizer (reset to 0) before the PINS mux.
  - An input change is first readable by a read whose sampling edge is the 3rd rising edge after the change (2 cycles of sync, then the read register).
- Not defined:
  - gpio_in feeds the PINS mux combinationally.
  - A change is captured by the next read edge.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then check gpio_out=0, gpio_dir=0, rdata=0. Assert reset mid-stream after writes; all outputs return to 0 with no clock edge required.
- Write DIR=0x0000000F, then OUT=0x00000005 with gpio_in=0: gpio_dir=0x0000000F and gpio_out=0x00000005. A read at 0x8 gives rdata=0x00000005.
- Set gpio_in=0x000000A0, wait 3 cycles, read 0x8 -> rdata=0x000000A5. Set gpio_in=0x0000000A with DIR=0xF -> still 0x000000A5 minus bits 7:4, i.e. 0x00000005 (input bits under output-mode pins are masked).
- With OUT=0x5, write 0xC with 0x0000000F -> gpio_out=0x0000000A. Then read 0xC -> rdata=0, and read 0x0 -> rdata=0x0000000A.
- Same-edge we=1/re=1 to addr 0x0 with wdata=0x12345678 while OUT=0xA -> rdata=0x0000000A and gpio_out=0x12345678. re=0 afterwards -> rdata holds.
- With GPIO_SYNC_EN defined, toggle gpio_in bit 8 (DIR bit 8 = 0) and read every cycle. The new value first appears in rdata from the read sampled on the 3rd edge after the change; the 1st and 2nd reads return the old value.
